// File: rtl/alp_param.sv
// rtl/alp_param.sv - parametrised arithmetic/logic processor with operand register file and iterative MUL/DIV
module alp_param #(
    parameter  int WIDTH = 4,
    parameter  int NREG  = 4,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic             load,
    input  logic             comp,
    input  logic             clr,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_regs [NREG];
    logic [AW-1:0]      r_wr_ptr;
    logic [WIDTH-1:0]   r_out_0;
    logic [WIDTH-1:0]   r_out_1;
    logic               r_err;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_shl;
    logic               w_b_big;
    logic [WIDTH-1:0]   w_sc_lo;
    logic [WIDTH-1:0]   w_sc_hi;
    logic               w_sc_err;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH:0]     w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic               w_last;

    assign w_a     = r_regs[src_a];
    assign w_b     = r_regs[src_b];
    assign w_add   = {1'b0, w_a} + {1'b0, w_b};
    assign w_shl   = {{WIDTH{1'b0}}, w_a} << w_b;
    assign w_b_big = 32'(w_b) >= 32'(WIDTH);

    always_comb begin
        w_sc_lo  = '0;
        w_sc_hi  = '0;
        w_sc_err = 1'b0;
        case (op)
            3'b000: begin
                w_sc_lo  = w_add[WIDTH-1:0];
                w_sc_hi  = {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
                w_sc_err = w_add[WIDTH];
            end
            3'b001: begin
                w_sc_lo  = w_a - w_b;
                w_sc_err = (w_a < w_b);
            end
            3'b010: w_sc_lo = w_a & w_b;
            3'b011: w_sc_lo = w_a | w_b;
            3'b100: w_sc_lo = w_a ^ w_b;
            3'b101: begin
                if (w_b_big) begin
                    w_sc_err = 1'b1;
                end else begin
                    {w_sc_hi, w_sc_lo} = w_shl;
                end
            end
            default: begin
                w_sc_lo  = '0;
                w_sc_hi  = '0;
                w_sc_err = 1'b0;
            end
        endcase
    end

    // One shift-add step for MUL and one restoring step for DIV per EXEC cycle.
    // A zero divisor naturally yields an all-ones quotient and remainder = A.
    assign w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_rem_ge = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nx = w_rem_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_rem_ge};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_wr_ptr  <= '0;
            r_out_0   <= '0;
            r_out_1   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_state  <= S_IDLE;
                for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
                r_wr_ptr <= '0;
                r_out_0  <= '0;
                r_out_1  <= '0;
                r_err    <= 1'b0;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (load) begin
                            r_regs[r_wr_ptr] <= data_in;
                            r_wr_ptr         <= r_wr_ptr + AW'(1);
                        end else if (comp) begin
                            if (op[2:1] == 2'b11) begin
                                r_state   <= S_EXEC;
                                r_busy    <= 1'b1;
                                r_cnt     <= '0;
                                r_is_div  <= op[0];
                                r_acc     <= '0;
                                r_mcand   <= {{WIDTH{1'b0}}, w_a};
                                r_mplier  <= w_b;
                                r_rem     <= '0;
                                r_quo     <= w_a;
                                r_divisor <= w_b;
                            end else begin
                                r_out_0 <= w_sc_lo;
                                r_out_1 <= w_sc_hi;
                                r_err   <= w_sc_err;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_EXEC: begin
                        r_cnt    <= r_cnt + CW'(1);
                        r_acc    <= w_acc_nx;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_rem    <= w_rem_nx;
                        r_quo    <= w_quo_nx;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_is_div) begin
                                r_out_0 <= w_quo_nx;
                                r_out_1 <= w_rem_nx[WIDTH-1:0];
                                r_err   <= (r_divisor == '0);
                            end else begin
                                {r_out_1, r_out_0} <= w_acc_nx;
                                r_err              <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_0 = r_out_0;
    assign out_1 = r_out_1;
    assign err   = r_err;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_alp_param.sv
// tb/tb_alp_param.sv - directed self-checking bench for alp_param (WIDTH=4, NREG=4)
module tb_alp_param;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_in;
    logic [2:0] op;
    logic       load;
    logic       comp;
    logic       clr;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] out_0;
    logic [3:0] out_1;
    logic       err;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int bcyc;

    alp_param #(.WIDTH(4), .NREG(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .op      (op),
        .load    (load),
        .comp    (comp),
        .clr     (clr),
        .src_a   (src_a),
        .src_b   (src_b),
        .out_0   (out_0),
        .out_1   (out_1),
        .err     (err),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; data_in = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_comp(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b);
        comp = 1'b1; op = o; src_a = a; src_b = b;
        step();
        comp = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [3:0] lo, input logic [3:0] hi, input logic e);
        check_eq({tag, ".out_0"}, 32'(out_0), 32'(lo));
        check_eq({tag, ".out_1"}, 32'(out_1), 32'(hi));
        check_eq({tag, ".err"},   32'(err),   32'(e));
        check_eq({tag, ".done"},  32'(done),  32'd1);
    endtask

    // Counts cycles with busy high after the start edge; optional load pulse during EXEC.
    task automatic run_multi(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                             input bit load_mid, output int cycles);
        do_comp(o, a, b);
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            if (load_mid && cycles == 1) begin
                load = 1'b1; data_in = 4'd3;
            end
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; data_in = '0; op = '0; load = 1'b0; comp = 1'b0;
        clr = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.out_0", 32'(out_0), 0);
        check_eq("rst.out_1", 32'(out_1), 0);
        check_eq("rst.err",   32'(err),   0);
        check_eq("rst.busy",  32'(busy),  0);
        check_eq("rst.done",  32'(done),  0);
        rst_n = 1'b1;
        step();

        do_load(4'd9); do_load(4'd7); do_load(4'd0);
        check_eq("load.done", 32'(done), 0);

        do_comp(3'b000, 2'd0, 2'd1);
        check_res("add", 4'd0, 4'd1, 1'b1);
        step();
        check_eq("add.done_drop", 32'(done), 0);
        check_eq("add.hold", 32'(out_1), 1);

        do_comp(3'b001, 2'd1, 2'd0);
        check_res("sub", 4'd14, 4'd0, 1'b1);
        do_comp(3'b101, 2'd0, 2'd1);
        check_res("shl_big", 4'd0, 4'd0, 1'b1);
        do_comp(3'b101, 2'd0, 2'd2);
        check_res("shl0", 4'd9, 4'd0, 1'b0);
        do_comp(3'b010, 2'd0, 2'd1);
        check_res("and", 4'd1, 4'd0, 1'b0);
        do_comp(3'b011, 2'd0, 2'd1);
        check_res("or", 4'd15, 4'd0, 1'b0);
        do_comp(3'b100, 2'd0, 2'd1);
        check_res("xor", 4'd14, 4'd0, 1'b0);

        run_multi(3'b110, 2'd0, 2'd1, 1'b1, bcyc);
        check_eq("mul.busy_cycles", 32'(bcyc), 4);
        check_res("mul", 4'd15, 4'd3, 1'b0);
        step();
        check_eq("mul.done_drop", 32'(done), 0);

        // Next load must land in reg3 if the load during EXEC was ignored.
        do_load(4'd12);
        do_comp(3'b000, 2'd3, 2'd2);
        check_res("reg3", 4'd12, 4'd0, 1'b0);
        do_comp(3'b000, 2'd0, 2'd1);
        check_res("regs_kept", 4'd0, 4'd1, 1'b1);

        run_multi(3'b111, 2'd0, 2'd1, 1'b0, bcyc);
        check_eq("div.busy_cycles", 32'(bcyc), 4);
        check_res("div", 4'd1, 4'd2, 1'b0);
        run_multi(3'b111, 2'd0, 2'd2, 1'b0, bcyc);
        check_eq("div0.busy_cycles", 32'(bcyc), 4);
        check_res("div0", 4'd15, 4'd9, 1'b1);

        // wr_ptr wrapped to 0 after the reg3 load; five loads end with reg0=5, wr_ptr=1.
        do_load(4'd1); do_load(4'd2); do_load(4'd3); do_load(4'd4); do_load(4'd5);
        do_comp(3'b000, 2'd0, 2'd2);
        check_res("wrap", 4'd8, 4'd0, 1'b0);
        load = 1'b1; comp = 1'b1; data_in = 4'd6; op = 3'b000; src_a = 2'd0; src_b = 2'd0;
        step();
        load = 1'b0; comp = 1'b0;
        check_eq("ldcomp.done", 32'(done), 0);
        check_eq("ldcomp.hold", 32'(out_0), 8);
        do_comp(3'b000, 2'd1, 2'd2);
        check_res("ldcomp.reg1", 4'd9, 4'd0, 1'b0);

        do_comp(3'b110, 2'd0, 2'd1);
        check_eq("clr.busy1", 32'(busy), 1);
        step();
        check_eq("clr.busy2", 32'(busy), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr.busy", 32'(busy), 0);
        check_eq("clr.out_0", 32'(out_0), 0);
        check_eq("clr.out_1", 32'(out_1), 0);
        check_eq("clr.done", 32'(done), 0);
        repeat (4) step();
        check_eq("clr.no_late_done", 32'(done), 0);

        do_load(4'd13); do_load(4'd4);
        do_comp(3'b000, 2'd0, 2'd1);
        check_res("pre_rst", 4'd1, 4'd1, 1'b1);
        do_comp(3'b111, 2'd0, 2'd1);
        step();
        check_eq("arst.busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        check_eq("arst.out_0", 32'(out_0), 0);
        check_eq("arst.out_1", 32'(out_1), 0);
        check_eq("arst.err",   32'(err),   0);
        check_eq("arst.busy",  32'(busy),  0);
        check_eq("arst.done",  32'(done),  0);
        rst_n = 1'b1;
        repeat (6) step();
        check_eq("arst.no_done", 32'(done), 0);
        check_eq("arst.idle",    32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alp_param.md
Name: alp_param

Overview:
- Parametrised successor to the 4-bit ALP: an arithmetic/logic processor with a loadable operand register file of NREG entries.
- Supports WIDTH-bit single-cycle ALU ops plus iterative multi-cycle MUL/DIV driven by an internal state machine.
- Produces a 2×WIDTH result split into out_0 (low/quotient) and out_1 (high/remainder), an err flag, and busy/done handshake outputs.
- Sits between the datapath input bus and the result display/consumer logic.

Parameters:
WIDTH, 4, operand/result half width in bits (≥2)
NREG, 4, number of operand registers (power of 2, ≥2); AW = clog2(NREG)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  operand load data
op  input  3  opcode, sampled with comp
load  input  1  write data_in to reg[wr_ptr]
comp  input  1  start operation on reg[src_a], reg[src_b]
clr  input  1  synchronous clear/abort
src_a  input  AW  operand A index
src_b  input  AW  operand B index
out_0  output  WIDTH  result low / quotient
out_1  output  WIDTH  result high / remainder
err  output  1  error/overflow flag for last result
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse when a result is written

Behaviour:
- Reset (rst_n=0, async, also mid-operation):
  - All regs, wr_ptr, out_0, out_1, err, busy and done go to 0.
  - State goes to IDLE; any op in flight is aborted.
- States: IDLE, EXEC. Outputs are registered.
- IDLE priority per edge: clr > load > comp.
  - clr: synchronous; zeros regs, wr_ptr and outputs; done=0.
  - load: reg[wr_ptr]<=data_in. wr_ptr increments and wraps NREG-1 -> 0. A comp asserted in the same cycle is ignored.
  - comp: A=reg[src_a] and B=reg[src_b] are captured at that edge.
- Opcodes:
  - 000 ADD: out_0=(A+B) mod 2^W; out_1={0…,carry}; err=carry.
  - 001 SUB: out_0=(A−B) mod 2^W; out_1=0; err=borrow (A<B).
  - 010 AND / 011 OR / 100 XOR: out_1=0; err=0.
  - 101 SHL: {out_1,out_0}=A<<B (2W-bit). If B≥WIDTH: result 0, err=1.
  - 110 MUL: {out_1,out_0}=A×B unsigned; err=0. Iterative shift-add.
  - 111 DIV: out_0=A/B; out_1=A mod B; err=0. Restoring, iterative.
    - B=0: out_0=all ones, out_1=A, err=1, same latency.
- Single-cycle ops (000–101): result and err written at the comp edge; done=1 for the following cycle; state stays IDLE.
- MUL/DIV:
  - The comp edge enters EXEC, busy<=1, iteration counter<=0.
  - One iteration per edge; after WIDTH iterations (edge k+WIDTH) the result is written, busy<=0, done<=1, state -> IDLE.
  - busy is high for exactly WIDTH cycles.
- In EXEC: load and comp are ignored (no write, no wr_ptr change, no restart); reg contents are unaffected.
  - clr aborts: next edge IDLE, busy=0, outputs 0, no done pulse.
- out_0, out_1 and err hold between results.
- done is 0 on every cycle not immediately following a result write.

Test Plan:
- WIDTH=4, NREG=4. Load 9,7,0 (wr_ptr 0..2), then comp op=000 src_a=0 src_b=1 -> after 1 edge: out_0=0, out_1=1, err=1, done pulses once.
- comp op=001 src_a=1 src_b=0 (7−9) -> out_0=14, out_1=0, err=1. Then op=101 A=9, B=7 -> out_0=0, out_1=0, err=1.
- comp op=110 src_a=0 src_b=1 (9×7) -> busy high 4 cycles; at 4th edge out_1=3, out_0=15, err=0, done=1. A load pulse during busy leaves wr_ptr=3 and the regs unchanged.
- comp op=111 9/7 -> out_0=1, out_1=2, err=0. comp op=111 9/0 (reg2) -> out_0=15, out_1=9, err=1 after 4 cycles.
- Load 5 values 1,2,3,4,5 from wr_ptr=0 -> reg0=5, wr_ptr=1 (wrap). load and comp asserted together -> only the write happens, no done.
- Start MUL, assert clr at 2nd busy cycle -> next edge busy=0, outputs 0, no done. Start DIV, pull rst_n low mid-op -> outputs/busy clear immediately, without waiting for a clock edge.
